shift_wb_queue: RTL and testbench
=================================

Name: shift_wb_queue

Overview:
- Result buffer directly downstream of the shift/bit-manip execution unit.
- Captures that unit's registered outputs (result, res_rd, res_makes_rd) every cycle. That unit has a fixed 2-stage pipeline and cannot be stalled.
- Buffers results in an in-order FIFO and drains them to the commit-register write port over a valid/ready handshake.
- Drives an issue-side stall so upstream stops enabling the shift unit before the FIFO can overflow.
- Supports per-hart kill of buffered results.

Parameters:
- RV, 64, datapath width.
- NHART, 1, number of harts.
- LNHART, 0, log2(NHART).
- LNCOMMIT, 5, commit register index width.
- DEPTH, 8, FIFO entries; power of 2, minimum 4.
- LDEPTH, 3, log2(DEPTH).
- INFLIGHT, 2, shift-unit pipeline depth used for the stall threshold.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- reset, in, 1, synchronous, active-high.
- in_result, in, RV, shift unit result.
- in_rd, in, LNCOMMIT, destination commit register.
- in_makes_rd, in, NHART, one-hot or zero; nonzero means a valid push for that hart.
- kill, in, NHART, discard all buffered and incoming entries of the flagged harts.
- wb_valid, out, 1, head entry valid.
- wb_ready, in, 1, write port accepts the head entry this cycle.
- wb_data, out, RV, head result.
- wb_rd, out, LNCOMMIT, head destination.
- wb_hart, out, NHART, one-hot hart of the head entry.
- issue_stall, out, 1, upstream must not assert the shift unit's enable.
- count, out, LDEPTH+1, current occupancy (registered).
- overflow, out, 1, sticky error flag.

Behaviour:
- Reset values: count=0, rd/wr pointers=0, all entry valid bits=0, overflow=0, wb_valid=0, issue_stall=0. wb_data, wb_rd and wb_hart are don't-care while wb_valid=0; the bench checks them only when wb_valid=1.
- Storage: DEPTH-entry circular buffer. Each entry holds data[RV], rd, hart[NHART] and a live bit. Pointers are LDEPTH bits and wrap modulo DEPTH. count is tracked separately, so full (count==DEPTH) and empty (count==0) are unambiguous.
- Push: push = |in_makes_rd. On push, the entry is written at wr_ptr with live=1, and wr_ptr increments.
  - If in_makes_rd & kill is nonzero, the entry is written with live=0. It still occupies a slot, which keeps count arithmetic uniform.
- Head: wb_valid = (count!=0) & head.live. Dead entries at the head are popped automatically, one per cycle, with wb_valid held at 0.
- Pop: pop = (count!=0) & (wb_ready | ~head.live), and rd_ptr increments. wb_ready has no effect when count==0.
- Latency: an entry pushed at edge N is presented at the earliest at edge N, i.e. visible in cycle N+1 (registered path). Write-back order equals push order.
- Count update: count_next = count + push - pop. Simultaneous push and pop at full or empty is legal.
  - Push at count==DEPTH with no pop: the entry is dropped, overflow is set (sticky until reset), and the pointers do not move.
  - Push and pop in the same cycle at count==DEPTH is accepted.
- Kill: every entry whose hart & kill is nonzero has live cleared at the edge. Count is unchanged; dead entries drain through the head-skip rule.
  - If kill hits the current head while wb_ready=1 in the same cycle, the write is still honoured. The kill applies from the next edge.
- Stall (combinational from registered state plus current push): issue_stall = (count + push) >= (DEPTH - INFLIGHT). This guarantees INFLIGHT ops already in the shift pipeline fit even if wb_ready stays low.
- Reset mid-operation: all entries are discarded at once with no write-back, and issue_stall deasserts the cycle after reset is applied.
- NHART==1: wb_hart is always 1 and kill is a single global flush.

Optional Feature:
- Macro: SHIFT_WBQ_BYPASS_EN.
- With the macro: when count==0 (or the queue holds only dead entries), push=1, the incoming entry is not killed and wb_ready=1, the incoming result is driven combinationally onto wb_* with wb_valid=1 in the same cycle. It is not written into the FIFO and count stays 0. issue_stall still uses the same formula.
- Without the macro: no combinational path from in_* to wb_*. Minimum latency is 1 cycle.

Test Plan:
- Reset, then push rd=3, data=0x00000000_0000F00D with wb_ready=1 -> next cycle wb_valid=1, wb_rd=3, wb_data=0xF00D, count returns to 0. With bypass: same-cycle wb_valid and count never leaves 0.
- wb_ready=0, push 6 back-to-back entries (DEPTH=8) -> issue_stall asserts in the cycle of the 6th push. Push 2 more -> count=8, overflow=0. A 9th push -> overflow=1, count stays 8, the dropped entry never appears.
- Full queue, push and pop in the same cycle with wb_ready=1 -> count stays 8. Output order is 0..8 minus the entry dropped in the previous scenario, with pointers wrapping past index 7.
- NHART=2: alternate hart0 and hart1 pushes rd=1..6, then kill=2'b10 with wb_ready=0, then wb_ready=1 -> only the hart0 entries (rd 1,3,5) are written back, in order. Dead entries cost one idle cycle each and count reaches 0.
- kill asserted together with a push for the same hart -> that entry never produces wb_valid. A simultaneous push for the other hart is written back normally.
- Assert reset with 5 live entries and wb_ready=1 -> no wb_valid after reset, count=0, issue_stall=0, overflow=0.

Source files
------------

// File: rtl/shift_wb_queue.sv
// In-order write-back buffer behind the non-stallable shift unit, with per-hart kill.
// Optional same-cycle bypass onto wb_* when the queue holds nothing live: SHIFT_WBQ_BYPASS_EN.
module shift_wb_queue #(
   parameter int unsigned RV       = 64,
   parameter int unsigned NHART    = 1,
   parameter int unsigned LNHART   = 0,
   parameter int unsigned LNCOMMIT = 5,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned LDEPTH   = 3,
   parameter int unsigned INFLIGHT = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [RV-1:0]       in_result,
   input  logic [LNCOMMIT-1:0] in_rd,
   input  logic [NHART-1:0]    in_makes_rd,
   input  logic [NHART-1:0]    kill,
   output logic                wb_valid,
   input  logic                wb_ready,
   output logic [RV-1:0]       wb_data,
   output logic [LNCOMMIT-1:0] wb_rd,
   output logic [NHART-1:0]    wb_hart,
   output logic                issue_stall,
   output logic [LDEPTH:0]     count,
   output logic                overflow
);

   localparam int unsigned CW = LDEPTH + 1;
   localparam int unsigned SW = LDEPTH + 2;

   if (NHART != (1 << LNHART) || DEPTH != (1 << LDEPTH) || DEPTH < 4) begin : g_param_err
      $error("shift_wb_queue: inconsistent NHART/LNHART or DEPTH/LDEPTH");
   end

   logic [RV-1:0]       mem_data [DEPTH];
   logic [LNCOMMIT-1:0] mem_rd   [DEPTH];
   logic [NHART-1:0]    mem_hart [DEPTH];
   logic [DEPTH-1:0]    live, live_next;
   logic [LDEPTH-1:0]   wr_ptr, rd_ptr;

   logic push, in_dead, not_empty, full, head_live, bypass, pop, wr_en;

   // Handshake and occupancy decisions for this cycle.
   always_comb begin
      push      = |in_makes_rd;
      in_dead   = |(in_makes_rd & kill);
      not_empty = (count != '0);
      full      = (count == CW'(DEPTH));
      head_live = live[rd_ptr];
`ifdef SHIFT_WBQ_BYPASS_EN
      bypass    = push & ~in_dead & wb_ready & ~(|live);
`else
      bypass    = 1'b0;
`endif
      pop       = not_empty & (wb_ready | ~head_live);
      wr_en     = push & ~bypass & (~full | pop);
   end

   // Head presentation; reset suppresses any write-back in the reset cycle.
   always_comb begin
      wb_valid = ~reset & (bypass | (not_empty & head_live));
      wb_data  = mem_data[rd_ptr];
      wb_rd    = mem_rd[rd_ptr];
      wb_hart  = mem_hart[rd_ptr];
`ifdef SHIFT_WBQ_BYPASS_EN
      if (bypass) begin
         wb_data = in_result;
         wb_rd   = in_rd;
         wb_hart = in_makes_rd;
      end
`endif
   end

   // Leaves headroom for INFLIGHT results already inside the shift pipeline.
   always_comb begin
      issue_stall = (SW'(count) + SW'(push)) >= SW'(DEPTH - INFLIGHT);
   end

   // Kill first, then retire the head, then the new entry claims its slot.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         live_next[i] = live[i] & ~(|(mem_hart[i] & kill));
      end
      if (pop)   live_next[rd_ptr] = 1'b0;
      if (wr_en) live_next[wr_ptr] = ~in_dead;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         live     <= '0;
         overflow <= 1'b0;
      end else begin
         live  <= live_next;
         count <= count + CW'(wr_en) - CW'(pop);
         if (wr_en) wr_ptr <= wr_ptr + LDEPTH'(1);
         if (pop)   rd_ptr <= rd_ptr + LDEPTH'(1);
         if (push & full & ~pop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data[wr_ptr] <= in_result;
         mem_rd[wr_ptr]   <= in_rd;
         mem_hart[wr_ptr] <= in_makes_rd;
      end
   end

endmodule

// File: tb/tb_shift_wb_queue.sv
// Scoreboard bench for shift_wb_queue (NHART=2) against a queue-level reference model.
module tb_shift_wb_queue;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned INFLIGHT = 2;

   typedef struct {
      logic [63:0] d;
      logic [4:0]  rd;
      logic [1:0]  h;
      bit          live;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] in_result = '0;
   logic [4:0]  in_rd = '0;
   logic [1:0]  in_makes_rd = '0;
   logic [1:0]  kill = '0;
   logic        wb_ready = 1'b0;
   logic        wb_valid;
   logic [63:0] wb_data;
   logic [4:0]  wb_rd;
   logic [1:0]  wb_hart;
   logic        issue_stall;
   logic [3:0]  count;
   logic        overflow;

   int checks = 0;
   int failures = 0;

   ent_t mq[$];
   ent_t exp_q[$];
   bit   m_ovf = 0;
   bit   mon_en = 0;
   bit   skip_state = 1;
   bit   exp_valid = 0;
   bit   exp_stall = 0;
   bit   exp_ovf = 0;
   int   exp_count = 0;

   shift_wb_queue #(.RV(64), .NHART(2), .LNHART(1), .LNCOMMIT(5),
                    .DEPTH(DEPTH), .LDEPTH(3), .INFLIGHT(INFLIGHT)) dut (
      .clk(clk), .reset(reset), .in_result(in_result), .in_rd(in_rd),
      .in_makes_rd(in_makes_rd), .kill(kill), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd), .wb_hart(wb_hart),
      .issue_stall(issue_stall), .count(count), .overflow(overflow));

   always #5 clk = ~clk;

   // Apply one cycle of inputs and advance the reference model past the coming edge.
   task automatic step(input bit rst, input logic [1:0] mk, input logic [4:0] rd,
                       input logic [63:0] d, input logic [1:0] kl, input bit rdy);
      ent_t e;
      bit p, dead, anylive, byp, popd;
      int sz;
      @(posedge clk); #1;
      reset = rst; in_makes_rd = mk; in_rd = rd; in_result = d; kill = kl; wb_ready = rdy;
      mon_en = 1;
      p = |mk;
      dead = |(mk & kl);
      sz = mq.size();
      anylive = 0;
      foreach (mq[i]) if (mq[i].live) anylive = 1;
      byp = 0;
`ifdef SHIFT_WBQ_BYPASS_EN
      byp = p && !dead && rdy && !anylive && !rst;
`endif
      if (rst) begin
         exp_valid = 0;
         skip_state = 1;
         mq.delete();
         m_ovf = 0;
      end else begin
         skip_state = 0;
         exp_count = sz;
         exp_stall = (sz + int'(p)) >= int'(DEPTH - INFLIGHT);
         exp_ovf = m_ovf;
         exp_valid = byp || (sz > 0 && mq[0].live);
         e.d = d; e.rd = rd; e.h = mk; e.live = !dead;
         if (byp) exp_q.push_back(e);
         else if (sz > 0 && mq[0].live && rdy) exp_q.push_back(mq[0]);
         popd = sz > 0 && (rdy || !mq[0].live);
         foreach (mq[i]) if ((mq[i].h & kl) != 2'b00) mq[i].live = 0;
         if (popd) void'(mq.pop_front());
         if (p && !byp) begin
            if (sz == int'(DEPTH) && !popd) m_ovf = 1;
            else mq.push_back(e);
         end
      end
   endtask

   task automatic idle(input bit rdy, input int n);
      for (int i = 0; i < n; i++) step(0, 2'b00, 5'd0, 64'd0, 2'b00, rdy);
   endtask

   // Monitor: compares presented write-backs against the scoreboard, plus status outputs.
   always @(negedge clk) begin
      if (mon_en) begin
         ent_t x;
         checks++;
         if (wb_valid !== exp_valid) begin
            failures++;
            $display("FAIL wb_valid: got %b want %b at %0t", wb_valid, exp_valid, $time);
         end
         if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL wb_unexpected: got rd=%0d data=%h, want no write-back", wb_rd, wb_data);
            end else begin
               x = exp_q.pop_front();
               if (wb_data !== x.d || wb_rd !== x.rd || wb_hart !== x.h) begin
                  failures++;
                  $display("FAIL wb_entry: got rd=%0d data=%h hart=%b want rd=%0d data=%h hart=%b",
                           wb_rd, wb_data, wb_hart, x.rd, x.d, x.h);
               end
            end
         end
         if (!skip_state) begin
            checks += 3;
            if (count !== 4'(exp_count)) begin
               failures++;
               $display("FAIL count: got %0d want %0d at %0t", count, exp_count, $time);
            end
            if (issue_stall !== exp_stall) begin
               failures++;
               $display("FAIL issue_stall: got %b want %b at %0t", issue_stall, exp_stall, $time);
            end
            if (overflow !== exp_ovf) begin
               failures++;
               $display("FAIL overflow: got %b want %b at %0t", overflow, exp_ovf, $time);
            end
         end
      end
   end

   initial begin
      logic [1:0] mk, kl;
      bit rdy, rst;
      step(1, 2'b00, 5'd0, 64'd0, 2'b00, 0);
      step(1, 2'b00, 5'd0, 64'd0, 2'b00, 0);
      idle(0, 1);

      // Single push, minimum latency.
      step(0, 2'b01, 5'd3, 64'h0000_0000_0000_F00D, 2'b00, 1);
      idle(1, 3);

      // Fill to full with the write port blocked, then one push too many.
      for (int i = 0; i < 9; i++)
         step(0, 2'b01, 5'(i), 64'h100 + 64'(i), 2'b00, 0);
      idle(0, 2);

      // Push and pop at full, then drain past the pointer wrap.
      for (int i = 0; i < 3; i++)
         step(0, 2'b01, 5'(20 + i), 64'h200 + 64'(i), 2'b00, 1);
      idle(1, 12);

      // Per-hart kill of buffered entries.
      step(1, 2'b00, 5'd0, 64'd0, 2'b00, 0);
      for (int i = 1; i <= 6; i++)
         step(0, (i % 2 == 1) ? 2'b01 : 2'b10, 5'(i), 64'hA0 + 64'(i), 2'b00, 0);
      step(0, 2'b00, 5'd0, 64'd0, 2'b10, 0);
      idle(1, 10);

      // Kill coinciding with a push for the same hart and for the other hart.
      step(0, 2'b10, 5'd9, 64'hDEAD, 2'b10, 1);
      step(0, 2'b01, 5'd10, 64'hBEEF, 2'b10, 1);
      idle(1, 4);

      // Reset with live entries pending.
      for (int i = 0; i < 5; i++)
         step(0, 2'b01, 5'(11 + i), 64'hC0 + 64'(i), 2'b00, 0);
      step(1, 2'b00, 5'd0, 64'd0, 2'b00, 1);
      idle(1, 3);

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(199) == 0);
         mk = 2'b00;
         if ($urandom_range(99) < 55 && !(mq.size() >= 5 && $urandom_range(3) != 0))
            mk = $urandom_range(1) ? 2'b10 : 2'b01;
         kl = ($urandom_range(19) == 0) ? 2'($urandom_range(3)) : 2'b00;
         rdy = ($urandom_range(99) < 60);
         step(rst, mk, 5'($urandom_range(31)), {$urandom, $urandom}, kl, rdy);
      end
      idle(1, 12);
      @(negedge clk); #1;
      mon_en = 0;

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL wb_missing: got %0d expected write-backs never presented, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
